mem_port_arbiter: RTL and testbench



---
 rtl/riscv_mem_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the unified instruction/data memory port arbiter.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (read-only) and data (read/write) requesters onto one
// fixed-latency single-ported memory, one transaction at a time.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
    localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              fetch_gnt_s, data_gnt_s;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_FETCH;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            starve_cnt_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Priority picker: data first, fetch once it has lost STARVE_MAX times in a row
    always_comb begin
        fetch_gnt_s = 1'b0;
        data_gnt_s  = 1'b0;
        if (state_q == ST_IDLE && !reset) begin
            if (data_req && fetch_req) begin
                if (starve_cnt_q == SC_W'(STARVE_MAX)) begin
                    fetch_gnt_s = 1'b1;
                end else begin
                    data_gnt_s = 1'b1;
                end
            end else if (data_req) begin
                data_gnt_s = 1'b1;
            end else if (fetch_req) begin
                fetch_gnt_s = 1'b1;
            end else begin
                fetch_gnt_s = 1'b0;
            end
        end else begin
            data_gnt_s = 1'b0;
        end
    end

    // Next-state and transaction latching; mem_* are loaded on grant so they show in ISSUE
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        starve_cnt_d = starve_cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_gnt_s) begin
                    owner_d      = OWN_FETCH;
                    we_d         = 1'b0;
                    mem_en_d     = 1'b1;
                    mem_addr_d   = fetch_addr;
                    starve_cnt_d = '0;
                    state_d      = ST_ISSUE;
                end else if (data_gnt_s) begin
                    owner_d     = OWN_DATA;
                    we_d        = data_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = data_we;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_wdata;
                    if (!fetch_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != SC_W'(STARVE_MAX)) begin
                        starve_cnt_d = starve_cnt_q + SC_W'(1);
                    end else begin
                        starve_cnt_d = starve_cnt_q;
                    end
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d = CNT_W'(MEM_LAT - 1);
                if (MEM_LAT > 1) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from state; read data passes straight through in RESP
    always_comb begin
        fetch_gnt    = fetch_gnt_s;
        data_gnt     = data_gnt_s;
        busy         = (state_q != ST_IDLE);
        fetch_rvalid = (state_q == ST_RESP) && (owner_q == OWN_FETCH);
        data_rvalid  = (state_q == ST_RESP) && (owner_q == OWN_DATA);
        mem_en       = mem_en_q;
        mem_we       = mem_we_q;
        mem_addr     = mem_addr_q;
        mem_wdata    = mem_wdata_q;
        if (fetch_rvalid) begin
            fetch_rdata = mem_rdata;
        end else begin
            fetch_rdata = '0;
        end
        if (data_rvalid && !we_q) begin
            data_rdata = mem_rdata;
        end else begin
            data_rdata = '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: fixed-latency memory model, scoreboard of expected
// read data per requester, directed timing checks for MEM_LAT=2 and MEM_LAT=1.
module mem_model_lat #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        pl_en,
    input  logic [31:0] pl_addr,
    input  logic [31:0] pl_data
);
    logic [31:0] mem  [0:255];
    logic [31:0] pipe [0:LAT-1];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr[7:0]] <= pl_data;
        if (en && we) mem[addr[7:0]] <= wdata;
        pipe[0] <= (en && !we) ? mem[addr[7:0]] : 32'hBAD0BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rdata = pipe[LAT-1];
endmodule

module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, fetch_gnt, fetch_rvalid;
    logic [31:0] fetch_addr, fetch_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_fetch_req, b_fetch_gnt, b_fetch_rvalid;
    logic [31:0] b_fetch_addr, b_fetch_rdata;
    logic        b_data_gnt, b_data_rvalid;
    logic [31:0] b_data_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    logic        pl_en_a, pl_en_b;
    logic [31:0] pl_addr, pl_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int f_gnt_cyc, d_gnt_cyc, f_rv_cyc, d_rv_cyc;
    logic        f_keep, d_keep;
    logic [31:0] last_drdata;
    logic [31:0] ref_mem [0:255];
    logic [31:0] fq [$];
    logic [31:0] dq [$];
    byte         glog [$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_model_lat #(.LAT(2)) mem_a (
        .clk(clk), .en(mem_en), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata),
        .rdata(mem_rdata), .pl_en(pl_en_a), .pl_addr(pl_addr), .pl_data(pl_data)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .reset(reset),
        .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr), .fetch_gnt(b_fetch_gnt),
        .fetch_rvalid(b_fetch_rvalid), .fetch_rdata(b_fetch_rdata),
        .data_req(1'b0), .data_we(1'b0), .data_addr(32'h0),
        .data_wdata(32'h0), .data_gnt(b_data_gnt), .data_rvalid(b_data_rvalid),
        .data_rdata(b_data_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    mem_model_lat #(.LAT(1)) mem_b (
        .clk(clk), .en(b_mem_en), .we(b_mem_we), .addr(b_mem_addr), .wdata(b_mem_wdata),
        .rdata(b_mem_rdata), .pl_en(pl_en_b), .pl_addr(pl_addr), .pl_data(pl_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sample the current cycle: scoreboard pushes on grants, pops on rvalid.
    task automatic look();
        #1;
        if (reset) begin
            fq.delete();
            dq.delete();
        end
        check("gnt_onehot", 64'(fetch_gnt & data_gnt), 64'd0);
        if (fetch_gnt) begin
            fq.push_back(ref_mem[fetch_addr[7:0]]);
            f_gnt_cyc = cyc;
            glog.push_back(8'h46);
        end
        if (data_gnt) begin
            dq.push_back(data_we ? 32'h0 : ref_mem[data_addr[7:0]]);
            if (data_we) ref_mem[data_addr[7:0]] = data_wdata;
            d_gnt_cyc = cyc;
            glog.push_back(8'h44);
        end
        if (fetch_rvalid) begin
            f_rv_cyc = cyc;
            if (fq.size() == 0) check("fetch_rv_unexpected", 64'(fetch_rvalid), 64'd0);
            else check("fetch_rdata_sb", 64'(fetch_rdata), 64'(fq.pop_front()));
            if (!f_keep) fetch_req = 1'b0;
        end
        if (data_rvalid) begin
            d_rv_cyc    = cyc;
            last_drdata = data_rdata;
            if (dq.size() == 0) check("data_rv_unexpected", 64'(data_rvalid), 64'd0);
            else check("data_rdata_sb", 64'(data_rdata), 64'(dq.pop_front()));
            if (!d_keep) data_req = 1'b0;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        look();
        adv();
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || fetch_req || data_req) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) check("timeout_idle", 64'({busy, fetch_req, data_req}), 64'd0);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d, input logic to_b);
        pl_addr = a;
        pl_data = d;
        pl_en_a = !to_b;
        pl_en_b = to_b;
        if (!to_b) ref_mem[a[7:0]] = d;
        tick();
        pl_en_a = 1'b0;
        pl_en_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sat_seen;
        reset = 1'b1;
        fetch_req = 1'b0; fetch_addr = 32'h0;
        data_req = 1'b0; data_we = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;
        b_fetch_req = 1'b0; b_fetch_addr = 32'h0;
        pl_en_a = 1'b0; pl_en_b = 1'b0; pl_addr = 32'h0; pl_data = 32'h0;
        f_keep = 1'b0; d_keep = 1'b0; last_drdata = 32'h0;
        f_gnt_cyc = -1; d_gnt_cyc = -1; f_rv_cyc = -1; d_rv_cyc = -1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        repeat (3) adv();
        reset = 1'b0;

        // Reset state
        look();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_rvalid", 64'({fetch_rvalid, data_rvalid}), 64'd0);
        check("rst_b_busy", 64'({b_busy, b_mem_en, b_fetch_rvalid}), 64'd0);
        adv();

        preload(32'h10, 32'h00500093, 1'b0);
        preload(32'h80, 32'h12345678, 1'b0);
        preload(32'h20, 32'hCAFEF00D, 1'b1);

        // Single fetch, MEM_LAT=2
        cyc = 0; f_rv_cyc = -1;
        fetch_addr = 32'h10; fetch_req = 1'b1;
        look();
        check("t1_fgnt", 64'(fetch_gnt), 64'd1);
        check("t1_dgnt", 64'(data_gnt), 64'd0);
        check("t1_busy_c0", 64'(busy), 64'd0);
        adv();
        look();
        check("t1_mem_en_c1", 64'(mem_en), 64'd1);
        check("t1_mem_we_c1", 64'(mem_we), 64'd0);
        check("t1_mem_addr_c1", 64'(mem_addr), 64'h10);
        check("t1_busy_c1", 64'(busy), 64'd1);
        adv();
        look();
        check("t1_mem_en_c2", 64'(mem_en), 64'd0);
        check("t1_busy_c2", 64'(busy), 64'd1);
        adv();
        look();
        check("t1_frv_c3", 64'(fetch_rvalid), 64'd1);
        check("t1_frdata_c3", 64'(fetch_rdata), 64'h00500093);
        check("t1_busy_c3", 64'(busy), 64'd1);
        adv();
        look();
        check("t1_busy_c4", 64'(busy), 64'd0);
        adv();
        wait_idle(20);

        // Simultaneous requests: data first, then fetch
        cyc = 0; f_gnt_cyc = -1; d_gnt_cyc = -1; f_rv_cyc = -1; d_rv_cyc = -1;
        fetch_addr = 32'h10; fetch_req = 1'b1;
        data_addr = 32'h80; data_we = 1'b0; data_req = 1'b1;
        repeat (9) tick();
        wait_idle(20);
        check("t2_dgnt_cyc", 64'(d_gnt_cyc), 64'd0);
        check("t2_drv_cyc", 64'(d_rv_cyc), 64'd3);
        check("t2_fgnt_cyc", 64'(f_gnt_cyc), 64'd4);
        check("t2_frv_cyc", 64'(f_rv_cyc), 64'd7);

        // Starvation: data re-requests continuously, fetch held
        glog.delete(); sat_seen = 1'b0;
        d_keep = 1'b1;
        fetch_addr = 32'h10; fetch_req = 1'b1;
        data_addr = 32'h80; data_we = 1'b0; data_req = 1'b1;
        for (int n = 0; n < 80 && glog.size() < 5; n++) begin
            tick();
            if (glog.size() == 4 && !sat_seen) begin
                sat_seen = 1'b1;
                check("t3_starve_sat", 64'(dut.starve_cnt_q), 64'd4);
            end
        end
        if (glog.size() >= 5) begin
            for (int i = 0; i < 5; i++)
                check($sformatf("t3_gnt%0d", i), 64'(glog[i]), (i < 4) ? 64'h44 : 64'h46);
            check("t3_starve_clr", 64'(dut.starve_cnt_q), 64'd0);
        end else begin
            check("t3_grant_count", 64'(glog.size()), 64'd5);
        end
        d_keep = 1'b0;
        wait_idle(60);

        // Data write then read-back
        cyc = 0; d_rv_cyc = -1;
        data_addr = 32'h40; data_wdata = 32'hDEADBEEF; data_we = 1'b1; data_req = 1'b1;
        look();
        check("t4_dgnt", 64'(data_gnt), 64'd1);
        adv();
        look();
        check("t4_mem_en", 64'(mem_en), 64'd1);
        check("t4_mem_we", 64'(mem_we), 64'd1);
        check("t4_mem_addr", 64'(mem_addr), 64'h40);
        check("t4_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        adv();
        tick();
        look();
        check("t4_drv_c3", 64'(data_rvalid), 64'd1);
        check("t4_drdata_c3", 64'(data_rdata), 64'd0);
        adv();
        wait_idle(20);
        data_we = 1'b0; data_addr = 32'h40; data_req = 1'b1;
        wait_idle(20);
        check("t4_readback", 64'(last_drdata), 64'hDEADBEEF);

        // Reset during WAIT of a fetch
        cyc = 0; f_rv_cyc = -1; f_gnt_cyc = -1;
        fetch_addr = 32'h10; fetch_req = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        look();
        adv();
        reset = 1'b0;
        look();
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_no_frv", 64'(fetch_rvalid), 64'd0);
        check("t5_mem_en", 64'(mem_en), 64'd0);
        check("t5_regrant", 64'(fetch_gnt), 64'd1);
        check("t5_no_rv_seen", 64'(f_rv_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        adv();
        wait_idle(20);
        check("t5_frv_cyc", 64'(f_rv_cyc), 64'd6);

        // MEM_LAT=1 instance: back-to-back fetches
        cyc = 0;
        b_fetch_addr = 32'h20; b_fetch_req = 1'b1;
        look();
        check("b_fgnt_c0", 64'(b_fetch_gnt), 64'd1);
        adv();
        look();
        check("b_mem_en_c1", 64'(b_mem_en), 64'd1);
        check("b_mem_addr_c1", 64'(b_mem_addr), 64'h20);
        check("b_fgnt_c1", 64'(b_fetch_gnt), 64'd0);
        adv();
        look();
        check("b_frv_c2", 64'(b_fetch_rvalid), 64'd1);
        check("b_frdata_c2", 64'(b_fetch_rdata), 64'hCAFEF00D);
        check("b_mem_en_c2", 64'(b_mem_en), 64'd0);
        adv();
        look();
        check("b_fgnt_c3", 64'(b_fetch_gnt), 64'd1);
        adv();
        tick();
        look();
        check("b_frv_c5", 64'(b_fetch_rvalid), 64'd1);
        b_fetch_req = 1'b0;
        adv();
        look();
        check("b_busy_c6", 64'(b_busy), 64'd0);
        adv();

        check("sb_empty", 64'(fq.size() + dq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
